vga_line_fetcher: RTL



---
 rtl/vga_fetch_pkg.sv | 22 ++
 rtl/line_ram.sv | 25 ++
 rtl/vga_line_fetcher.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/vga_fetch_pkg.sv
// Shared types and helpers for the VGA line prefetcher: fetch FSM states,
// bank selector and the wrap-around row arithmetic.
package vga_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN
    } fetch_state_t;

    typedef logic bank_sel_t;

    // (r + step) mod v_pixels for r < v_pixels and a small step; 32-bit math cannot overflow.
    function automatic int unsigned row_plus(input int unsigned r,
                                             input int unsigned step,
                                             input int unsigned v_pixels);
        int unsigned sum;
        sum = r + step;
        return (sum >= v_pixels) ? sum - v_pixels : sum;
    endfunction

endpackage

// File: rtl/line_ram.sv
// Simple dual-port line RAM: one write port, one registered read port.
module line_ram #(
    parameter int DEPTH      = 640,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset; a bank's valid bit in the fetcher guards stale contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/vga_line_fetcher.sv
// Prefetches upcoming display rows from frame memory into a two-bank line
// buffer and serves pixels by (row, col) with one cycle of latency.
module vga_line_fetcher
    import vga_fetch_pkg::*;
#(
    parameter int COL_WIDTH       = 10,
    parameter int ROW_WIDTH       = 9,
    parameter int H_PIXELS        = 640,
    parameter int V_PIXELS        = 480,
    parameter int DATA_WIDTH      = 8,
    parameter int ADDR_WIDTH      = 19,
    parameter int BASE_ADDR       = 0,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  end_line,
    input  logic [ROW_WIDTH-1:0]  row,
    input  logic [COL_WIDTH-1:0]  col,
    input  logic                  disp_ena,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data,
    output logic [DATA_WIDTH-1:0] pixel,
    output logic                  underrun,
    output logic                  overrun,
    output logic                  busy
);

    localparam int CNT_W  = $clog2(H_PIXELS + 1);
    localparam int RAM_AW = $clog2(H_PIXELS);
    localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);

    fetch_state_t          state, state_next;
    logic [1:0]            bank_valid;
    logic [ROW_WIDTH-1:0]  bank_tag [2];
    bank_sel_t             victim;
    logic [ADDR_WIDTH-1:0] row_base;
    logic [CNT_W-1:0]      req_cnt;
    logic [CNT_W-1:0]      wr_cnt;
    logic [OUT_W-1:0]      outstanding;

    logic [ROW_WIDTH-1:0]  next_row;
    logic [ROW_WIDTH-1:0]  target_row;
    logic                  target_hit;
    bank_sel_t             victim_pick;
    logic [ADDR_WIDTH-1:0] fetch_base;
    logic                  start_fetch;
    logic                  accept;
    logic                  rsp_take;
    logic                  fill_done;

    logic                  hit0, hit1;
    logic                  rd_hit;
    bank_sel_t             rd_sel;
    logic [DATA_WIDTH-1:0] rd_data0, rd_data1;

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        next_row    = ROW_WIDTH'(row_plus(32'(row), 1, V_PIXELS));
        target_row  = ROW_WIDTH'(row_plus(32'(row), 2, V_PIXELS));
        target_hit  = (bank_valid[0] && bank_tag[0] == target_row) ||
                      (bank_valid[1] && bank_tag[1] == target_row);
        // Keep whichever bank holds the row about to be displayed.
        victim_pick = (bank_tag[0] != next_row) ? 1'b0 : 1'b1;
        fetch_base  = ADDR_WIDTH'(BASE_ADDR + int'(target_row) * H_PIXELS);
        start_fetch = end_line && (state == IDLE) && !target_hit;

        mem_req_valid = (state == REQ) && (req_cnt < CNT_W'(H_PIXELS)) &&
                        (outstanding < OUT_W'(MAX_OUTSTANDING));
        mem_req_addr  = row_base + ADDR_WIDTH'(req_cnt);
        accept        = mem_req_valid && mem_req_ready;
        rsp_take      = mem_rsp_valid && (state != IDLE) && (wr_cnt < CNT_W'(H_PIXELS));
        fill_done     = (outstanding == '0) && (wr_cnt == CNT_W'(H_PIXELS));

        state_next = state;
        case (state)
            IDLE:    if (start_fetch) state_next = REQ;
            REQ:     if (accept && req_cnt == CNT_W'(H_PIXELS - 1)) state_next = DRAIN;
            DRAIN:   if (fill_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            bank_valid  <= '0;
            bank_tag[0] <= '0;
            bank_tag[1] <= '0;
            victim      <= 1'b0;
            row_base    <= '0;
            req_cnt     <= '0;
            wr_cnt      <= '0;
            outstanding <= '0;
            overrun     <= 1'b0;
        end else begin
            state   <= state_next;
            overrun <= end_line && (state != IDLE);

            if (start_fetch) begin
                victim                 <= victim_pick;
                bank_valid[victim_pick] <= 1'b0;
                bank_tag[victim_pick]  <= target_row;
                row_base               <= fetch_base;
                req_cnt                <= '0;
                wr_cnt                 <= '0;
            end

            if (accept)   req_cnt <= req_cnt + 1'b1;
            if (rsp_take) wr_cnt  <= wr_cnt + 1'b1;

            case ({accept, rsp_take})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase

            if (state == DRAIN && fill_done) begin
                bank_valid[victim] <= 1'b1;
            end
        end
    end

    // Display read path: RAM read and hit decision are both registered, giving latency 1.
    assign hit0 = bank_valid[0] && (bank_tag[0] == row);
    assign hit1 = bank_valid[1] && (bank_tag[1] == row);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_hit   <= 1'b0;
            rd_sel   <= 1'b0;
            underrun <= 1'b0;
        end else begin
            rd_hit   <= disp_ena && (hit0 || hit1);
            rd_sel   <= hit1;
            underrun <= disp_ena && !(hit0 || hit1);
        end
    end

    assign pixel = rd_hit ? (rd_sel ? rd_data1 : rd_data0) : '0;

    line_ram #(
        .DEPTH      (H_PIXELS),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (RAM_AW)
    ) u_bank0 (
        .clk     (clk),
        .wr_en   (rsp_take && (victim == 1'b0)),
        .wr_addr (wr_cnt[RAM_AW-1:0]),
        .wr_data (mem_rsp_data),
        .rd_addr (col[RAM_AW-1:0]),
        .rd_data (rd_data0)
    );

    line_ram #(
        .DEPTH      (H_PIXELS),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (RAM_AW)
    ) u_bank1 (
        .clk     (clk),
        .wr_en   (rsp_take && (victim == 1'b1)),
        .wr_addr (wr_cnt[RAM_AW-1:0]),
        .wr_data (mem_rsp_data),
        .rd_addr (col[RAM_AW-1:0]),
        .rd_data (rd_data1)
    );

endmodule
